// File: rtl/acq_ram_writer.sv
// Write-side sequencer for a circular acquisition RAM.
// Flow: arm -> pre-trigger fill -> wait for trigger -> post-trigger fill -> done.
// Every accepted sample reaches the RAM port exactly one cycle after it is strobed.
module acq_ram_writer #(
  parameter int unsigned g_addr_width = 9,
  parameter int unsigned g_data_width = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    arm_i,
  input  logic                    abort_i,
  input  logic [g_addr_width-1:0] pretrig_i,
  input  logic [g_addr_width-1:0] posttrig_i,
  input  logic                    sample_valid_i,
  input  logic [g_data_width-1:0] sample_i,
  input  logic                    trig_i,
  output logic [g_addr_width-1:0] ram_adr_o,
  output logic                    ram_we_o,
  output logic [g_data_width-1:0] ram_dat_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [g_addr_width-1:0] trig_adr_o,
  output logic [g_addr_width-1:0] start_adr_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]              r_state;
  logic [g_addr_width-1:0] r_wptr;
  logic [g_addr_width-1:0] r_pre_cnt;
  logic [g_addr_width-1:0] r_post_cnt;
  logic [g_addr_width-1:0] r_pretrig;
  logic [g_addr_width-1:0] r_posttrig;
  logic [g_addr_width-1:0] r_ram_adr;
  logic                    r_ram_we;
  logic [g_data_width-1:0] r_ram_dat;
  logic                    r_busy;
  logic                    r_done;
  logic [g_addr_width-1:0] r_trig_adr;
  logic [g_addr_width-1:0] r_start_adr;

  logic [2:0]              w_state_d;
  logic                    w_write;
  logic                    w_arm_ok;
  logic                    w_trig_hit;
  logic [g_addr_width-1:0] w_pre_cnt_inc;
  logic [g_addr_width-1:0] w_post_cnt_inc;

  // Next-state decode; abort overrides everything, including the sample write.
  always_comb begin
    w_state_d      = r_state;
    w_write        = 1'b0;
    w_trig_hit     = 1'b0;
    w_arm_ok       = 1'b0;
    w_pre_cnt_inc  = r_pre_cnt + 1'b1;
    w_post_cnt_inc = r_post_cnt + 1'b1;
    if (abort_i) begin
      w_state_d = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            w_arm_ok  = 1'b1;
            w_state_d = (pretrig_i == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (sample_valid_i) begin
            w_write = 1'b1;
            if (w_pre_cnt_inc == r_pretrig) w_state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (sample_valid_i) begin
            w_write = 1'b1;
            if (trig_i) begin
              w_trig_hit = 1'b1;
              w_state_d  = (r_posttrig == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid_i) begin
            w_write = 1'b1;
            if (w_post_cnt_inc == r_posttrig) w_state_d = S_DONE;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  // State, pointers, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_pretrig   <= '0;
      r_posttrig  <= '0;
      r_ram_adr   <= '0;
      r_ram_we    <= 1'b0;
      r_ram_dat   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trig_adr  <= '0;
      r_start_adr <= '0;
    end else begin
      r_state  <= w_state_d;
      r_busy   <= (w_state_d == S_PRE) || (w_state_d == S_WAIT) || (w_state_d == S_POST);
      r_done   <= (w_state_d == S_DONE);
      r_ram_we <= w_write;
      if (w_write) begin
        r_ram_adr <= r_wptr;
        r_ram_dat <= sample_i;
        r_wptr    <= r_wptr + 1'b1;
      end
      if (w_arm_ok) begin
        r_pretrig  <= pretrig_i;
        r_posttrig <= posttrig_i;
        r_wptr     <= '0;
        r_pre_cnt  <= '0;
      end
      if (w_write && (r_state == S_PRE)) r_pre_cnt <= w_pre_cnt_inc;
      if (w_write && (r_state == S_POST)) r_post_cnt <= w_post_cnt_inc;
      if (w_trig_hit) begin
        r_trig_adr  <= r_wptr;
        r_start_adr <= r_wptr - r_pretrig;
        r_post_cnt  <= '0;
      end
    end
  end

  assign ram_adr_o   = r_ram_adr;
  assign ram_we_o    = r_ram_we;
  assign ram_dat_o   = r_ram_dat;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign trig_adr_o  = r_trig_adr;
  assign start_adr_o = r_start_adr;

endmodule

// File: doc/acq_ram_writer.md
Name: acq_ram_writer

Overview:
- Write-side sequencer for a single-port-write acquisition RAM, e.g. the acqVP value memory: drives the RAM port B address, write enable and data from a sample stream.
- Implements arm -> pre-trigger fill -> wait trigger -> post-trigger fill -> done, writing a circular buffer.
- Reports the trigger address and the window start address, so the VME read side can locate the captured window.
- Sits between the acquisition datapath and the memory's external RAM port. The VME read path is unaffected.

Parameters:
g_addr_width, 9, RAM address width; buffer depth = 2**g_addr_width samples
g_data_width, 16, sample / RAM data width

Ports:
Clk  in  1  system clock; all logic on rising edge
Rst  in  1  synchronous, active-high reset
arm_i  in  1  start-acquisition pulse (one cycle)
abort_i  in  1  abort pulse; returns the block to IDLE
pretrig_i  in  g_addr_width  number of samples required before a trigger is accepted
posttrig_i  in  g_addr_width  number of samples written after the trigger sample
sample_valid_i  in  1  sample strobe
sample_i  in  g_data_width  sample data
trig_i  in  1  trigger; only meaningful when sample_valid_i=1
ram_adr_o  out  g_addr_width  RAM write address
ram_we_o  out  1  RAM write enable (one cycle per sample)
ram_dat_o  out  g_data_width  RAM write data
busy_o  out  1  state is PRE, WAIT_TRIG or POST
done_o  out  1  capture complete; window valid
trig_adr_o  out  g_addr_width  address where the trigger sample was written
start_adr_o  out  g_addr_width  trig_adr_o - pretrig (latched value), modulo depth

Behaviour:
- Reset (Rst=1 at a clock edge, in any state, including mid-capture):
  - state=IDLE.
  - All outputs 0, and wptr, counters and latched pretrig/posttrig also 0.
- States:
  - IDLE, PRE, WAIT_TRIG, POST and DONE.
  - abort_i=1 takes priority over everything: next state IDLE, done_o=0, no write is issued for that cycle's sample. RAM contents are left unchanged.
- Arm:
  - arm_i=1 in IDLE or DONE does all of the following:
    - latches pretrig_i and posttrig_i;
    - sets wptr=0 and pre_cnt=0;
    - clears done_o;
    - moves to PRE, or to WAIT_TRIG if pretrig_i=0.
  - arm_i while busy_o=1 is ignored.
  - A sample with sample_valid_i in the arm cycle is not written.
- Write pipeline:
  - Applies in PRE, WAIT_TRIG and POST.
  - A sample with sample_valid_i=1 at edge N produces ram_we_o=1, ram_adr_o=wptr and ram_dat_o=sample_i during cycle N+1. Latency is exactly 1 cycle.
  - wptr then increments modulo 2**g_addr_width; address (2**g_addr_width)-1 wraps to 0.
  - ram_we_o=0 in any cycle not following a valid sample. ram_adr_o and ram_dat_o hold their last values.
  - Back-to-back valid samples (every cycle) are supported with no bubbles.
- PRE:
  - Each valid sample increments pre_cnt.
  - When the sample making pre_cnt equal to the latched pretrig is accepted, move to WAIT_TRIG.
  - trig_i is ignored in PRE, including on that last sample.
- WAIT_TRIG:
  - Valid samples are written circularly with no limit.
  - A sample with sample_valid_i=1 and trig_i=1 is the trigger sample. It is written at wptr, and trig_adr_o := wptr and start_adr_o := wptr - pretrig are latched.
  - post_cnt is cleared.
  - If the latched posttrig=0, go to DONE; otherwise go to POST.
- POST:
  - trig_i is ignored.
  - Each valid sample is written and increments post_cnt.
  - When post_cnt reaches posttrig, go to DONE.
- DONE:
  - done_o=1 and busy_o=0; no writes.
  - trig_adr_o and start_adr_o are held.
  - Stays in DONE until arm_i or abort_i.
  - The last post-trigger write appears on the RAM port in the first cycle of DONE (pipeline drain). This write must still occur.
- Window sizing:
  - Total window = pretrig + 1 + posttrig samples.
  - Software keeps this ≤ 2**g_addr_width; there is no hardware check.
  - If exceeded, the oldest pre-trigger samples are overwritten and the addresses are computed the same way.
- Timing of status outputs: done_o, busy_o, trig_adr_o and start_adr_o are registered and update on the edge the state changes.

Test Plan:
1. Reset mid-POST: Rst=1 for one cycle -> next cycle state IDLE, all outputs 0, and no ram_we_o thereafter until re-armed.
2. Basic capture:
   - Setup: pretrig=4, posttrig=3, continuous valid samples 0x0000,0x0001,..., trig_i on the sample 0x0006.
   - Required: writes at addresses 0..9 with data 0..9; trig_adr_o=6, start_adr_o=2, done_o=1 after the data-9 write; no further writes.
3. Trigger in PRE ignored: pretrig=4, trig_i on sample 2 -> still WAIT_TRIG after sample 4; trigger on sample 5 -> trig_adr_o=5.
4. Wrap-around:
   - Setup: pretrig=2, posttrig=1, trigger on sample 513 (written at address 1).
   - Required: address 511 followed by address 0, trig_adr_o=1, start_adr_o=511.
5. Zero counts and gaps: pretrig=0, posttrig=0, sample_valid every 3rd cycle, trig on the first valid -> single write at address 0, DONE one cycle after it, ram_we_o low in gap cycles.
6. Control priority:
   - arm_i while busy -> ignored, wptr unchanged.
   - abort_i and arm_i in the same cycle in DONE -> IDLE, done_o=0.
   - arm_i from DONE -> new capture restarts at address 0.
